// File: rtl/dpram_pkg.sv
// dpram_pkg
//   Shared types and constants for the self-clearing dual-port RAM.
//   - clr_state_t  : clear sequencer FSM state (IDLE, CLEAR)
//   - RDW_OLD_DATA : read-during-write returns the pre-write word
//   - RDW_NEW_DATA : read-during-write returns the merged post-write word
package dpram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int RDW_OLD_DATA = 0;
    localparam int RDW_NEW_DATA = 1;

endpackage

// File: rtl/dpram_clear_seq.sv
// dpram_clear_seq
//   Clear sequencer: walks every word address once, issuing a write strobe
//   per cycle, and reports busy for the whole sweep.
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   async active-low reset (restarts the sweep at 0)
//   clear_req  in   one-cycle request, honoured only in IDLE
//   busy       out  high while the sweep runs (registered)
//   sweep_addr out  word address being cleared this cycle
//   sweep_we   out  clear write strobe
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_req,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] sweep_addr,
    output logic                  sweep_we
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    clr_state_t            state, state_nxt;
    // One extra bit so the sweep end is seen as the MSB setting, not a wrap.
    logic [ADDR_WIDTH:0]   cnt, cnt_nxt;
    logic                  busy_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy_q <= (state_nxt == CLEAR);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (clear_req) state_nxt = CLEAR;
            end
            CLEAR: begin
                // clear_req is deliberately not looked at here: no restart.
                cnt_nxt = cnt + CNT_ONE;
                if (cnt_nxt[ADDR_WIDTH]) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy       = busy_q;
    assign sweep_we   = (state == CLEAR);
    assign sweep_addr = cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/dpram_init.sv
// dpram_init
//   True dual-port RAM with byte-lane write enables, configurable
//   read-during-write behaviour and a full-memory clear sweep that runs
//   after reset and on request. Port accesses are ignored while busy.
// Ports
//   clock, reset_n          clock / async active-low reset
//   clear_req, busy         clear request / sweep in progress
//   enable_x, wren_x, be_x  per-port access, write and byte-lane enables
//   address_x, data_x       per-port word address / write data
//   q_x                     per-port registered read data
//   collision               one-cycle pulse on a same-address dual write
module dpram_init
    import dpram_pkg::*;
#(
    parameter int                                ADDR_WIDTH  = 8,
    parameter int                                DATA_WIDTH  = 8,
    parameter int                                BYTE_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0]             CLEAR_VALUE = '0,
    parameter int                                RDW_NEW     = 0
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  clear_req,
    output logic                                  busy,
    input  logic                                  enable_a,
    input  logic                                  enable_b,
    input  logic                                  wren_a,
    input  logic                                  wren_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]      be_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]      be_b,
    input  logic [ADDR_WIDTH-1:0]                 address_a,
    input  logic [ADDR_WIDTH-1:0]                 address_b,
    input  logic [DATA_WIDTH-1:0]                 data_a,
    input  logic [DATA_WIDTH-1:0]                 data_b,
    output logic [DATA_WIDTH-1:0]                 q_a,
    output logic [DATA_WIDTH-1:0]                 q_b,
    output logic                                  collision
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  sweep_we;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic                  rd_a, rd_b, wr_a, wr_b, same_addr;
    logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b;

    dpram_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .busy       (busy),
        .sweep_addr (sweep_addr),
        .sweep_we   (sweep_we)
    );

    assign rd_a      = enable_a & ~busy;
    assign rd_b      = enable_b & ~busy;
    assign wr_a      = rd_a & wren_a;
    assign wr_b      = rd_b & wren_b;
    assign same_addr = (address_a == address_b);
    assign old_a     = mem[address_a];
    assign old_b     = mem[address_b];

    // Post-write word seen at each port's address. Port B lanes are applied
    // first so port A overwrites them on a same-address collision; lanes only
    // B enables still take data_b.
    always_comb begin
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (wr_b && be_b[i]) begin
                new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (same_addr)
                    new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (wr_a && be_a[i]) begin
                new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (same_addr)
                    new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Storage is never reset; it becomes defined once the sweep completes.
    // On a same-address dual write new_a == new_b, so both writes agree.
    always_ff @(posedge clock) begin
        if (sweep_we) begin
            mem[sweep_addr] <= CLEAR_VALUE;
        end else begin
            if (wr_a) mem[address_a] <= new_a;
            if (wr_b) mem[address_b] <= new_b;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_a       <= '0;
            q_b       <= '0;
            collision <= 1'b0;
        end else begin
            if (rd_a) q_a <= (RDW_NEW == RDW_NEW_DATA) ? new_a : old_a;
            if (rd_b) q_b <= (RDW_NEW == RDW_NEW_DATA) ? new_b : old_b;
            collision <= wr_a & wr_b & same_addr;
        end
    end

endmodule

// File: tb/tb_dpram_init.sv
// tb_dpram_init
//   Directed bench: two 8-bit instances (old-data and new-data
//   read-during-write, sharing stimulus) and one 16-bit instance for
//   byte-lane merging.
module tb_dpram_init;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b1;
    logic       clear_req = 1'b0;
    logic       en_a = 0, en_b = 0, wr_a = 0, wr_b = 0;
    logic [0:0] be_a = 1'b1, be_b = 1'b1;
    logic [3:0] addr_a = 0, addr_b = 0;
    logic [7:0] d_a = 0, d_b = 0;

    logic       o_busy, o_coll, n_busy, n_coll;
    logic [7:0] o_q_a, o_q_b, n_q_a, n_q_b;

    logic        w_clear = 1'b0;
    logic        w_en_a = 0, w_en_b = 0, w_wr_a = 0, w_wr_b = 0;
    logic [1:0]  w_be_a = 0, w_be_b = 0;
    logic [3:0]  w_addr_a = 0, w_addr_b = 0;
    logic [15:0] w_d_a = 0, w_d_b = 0;
    logic [15:0] w_q_a, w_q_b;
    logic        w_busy, w_coll;

    int checks = 0;
    int fails  = 0;
    int n;

    always #5 clock = ~clock;

    dpram_init #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .BYTE_WIDTH(8),
                 .CLEAR_VALUE(8'hA5), .RDW_NEW(0)) u_old (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(o_busy),
        .enable_a(en_a), .enable_b(en_b), .wren_a(wr_a), .wren_b(wr_b),
        .be_a(be_a), .be_b(be_b), .address_a(addr_a), .address_b(addr_b),
        .data_a(d_a), .data_b(d_b), .q_a(o_q_a), .q_b(o_q_b), .collision(o_coll));

    dpram_init #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .BYTE_WIDTH(8),
                 .CLEAR_VALUE(8'h00), .RDW_NEW(1)) u_new (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(n_busy),
        .enable_a(en_a), .enable_b(en_b), .wren_a(wr_a), .wren_b(wr_b),
        .be_a(be_a), .be_b(be_b), .address_a(addr_a), .address_b(addr_b),
        .data_a(d_a), .data_b(d_b), .q_a(n_q_a), .q_b(n_q_b), .collision(n_coll));

    dpram_init #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8),
                 .CLEAR_VALUE(16'h0000), .RDW_NEW(0)) u_wide (
        .clock(clock), .reset_n(reset_n), .clear_req(w_clear), .busy(w_busy),
        .enable_a(w_en_a), .enable_b(w_en_b), .wren_a(w_wr_a), .wren_b(w_wr_b),
        .be_a(w_be_a), .be_b(w_be_b), .address_a(w_addr_a), .address_b(w_addr_b),
        .data_a(w_d_a), .data_b(w_d_b), .q_a(w_q_a), .q_b(w_q_b), .collision(w_coll));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_ports();
        en_a = 0; en_b = 0; wr_a = 0; wr_b = 0;
        w_en_a = 0; w_en_b = 0; w_wr_a = 0; w_wr_b = 0;
    endtask

    // Counts edges until busy drops; a full sweep is 16 edges for ADDR_WIDTH=4.
    task automatic wait_sweep(output int cnt);
        cnt = 0;
        while (o_busy && cnt < 100) begin
            cyc();
            cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #1 reset_n = 1'b0;
        #2;
        chk("rst_busy",  o_busy, 1);
        chk("rst_q_a",   o_q_a,  0);
        chk("rst_q_b",   o_q_b,  0);
        chk("rst_coll",  o_coll, 0);
        chk("rst_wbusy", w_busy, 1);
        #19 reset_n = 1'b1;

        // Initial sweep: 16 busy cycles, then every word reads A5
        wait_sweep(n);
        chk("sweep_len", n, 16);
        chk("wbusy_done", w_busy, 0);
        for (int i = 0; i < 16; i++) begin
            en_a = 1; addr_a = 4'(i);
            en_b = 1; addr_b = 4'(15 - i);
            cyc();
            chk("clr_rd_a", o_q_a, 8'hA5);
            chk("clr_rd_b", o_q_b, 8'hA5);
        end
        idle_ports();

        // Byte-lane merge on the 16-bit instance
        w_en_a = 1; w_wr_a = 1; w_be_a = 2'b11; w_addr_a = 3; w_d_a = 16'h1234;
        cyc();
        w_be_a = 2'b10; w_d_a = 16'hFF00;
        cyc();
        chk("w_rdw_old", w_q_a, 16'h1234);
        w_wr_a = 0;
        cyc();
        chk("w_merge", w_q_a, 16'hFF34);
        w_en_a = 0; w_addr_a = 0;
        cyc();
        chk("w_hold", w_q_a, 16'hFF34);

        // Partial-lane collision: A lane0 wins, lane1 only from B
        w_en_a = 1; w_wr_a = 1; w_be_a = 2'b01; w_addr_a = 7; w_d_a = 16'h11AA;
        w_en_b = 1; w_wr_b = 1; w_be_b = 2'b11; w_addr_b = 7; w_d_b = 16'h22BB;
        cyc();
        chk("w_coll", w_coll, 1);
        idle_ports();
        w_en_a = 1; w_addr_a = 7;
        cyc();
        chk("w_coll_data", w_q_a, 16'h22AA);
        chk("w_coll_end", w_coll, 0);
        idle_ports();

        // Full-lane dual write to address 5
        en_a = 1; wr_a = 1; addr_a = 5; d_a = 8'h11;
        en_b = 1; wr_b = 1; addr_b = 5; d_b = 8'h22;
        cyc();
        chk("coll_old", o_coll, 1);
        chk("coll_new", n_coll, 1);
        idle_ports();
        en_a = 1; addr_a = 5;
        cyc();
        chk("coll_pulse", o_coll, 0);
        chk("coll_mem_o", o_q_a, 8'h11);
        chk("coll_mem_n", n_q_a, 8'h11);

        // Dual write to different addresses: no collision
        en_a = 1; wr_a = 1; addr_a = 1; d_a = 8'h01;
        en_b = 1; wr_b = 1; addr_b = 2; d_b = 8'h02;
        cyc();
        chk("no_coll", o_coll, 0);
        idle_ports();

        // Read-during-write, cross-port and same-port
        en_a = 1; wr_a = 1; addr_a = 9; d_a = 8'h00;
        cyc();
        en_a = 1; wr_a = 1; addr_a = 9; d_a = 8'h77;
        en_b = 1; wr_b = 0; addr_b = 9;
        cyc();
        chk("xrdw_old", o_q_b, 8'h00);
        chk("xrdw_new", n_q_b, 8'h77);
        chk("srdw_old", o_q_a, 8'h00);
        chk("srdw_new", n_q_a, 8'h77);
        d_a = 8'h33;
        cyc();
        chk("srdw_old2", o_q_a, 8'h77);
        chk("srdw_new2", n_q_a, 8'h33);
        chk("xrdw_old2", o_q_b, 8'h77);
        chk("xrdw_new2", n_q_b, 8'h33);
        idle_ports();

        // Accesses while busy are ignored; clear_req mid-sweep does not restart
        en_a = 1; addr_a = 5; en_b = 1; addr_b = 9;
        cyc();
        chk("pre_q_a", o_q_a, 8'h11);
        chk("pre_q_b", o_q_b, 8'h33);
        idle_ports();
        clear_req = 1;
        cyc();
        clear_req = 0;
        chk("clr_busy", o_busy, 1);
        en_a = 1; wr_a = 1; addr_a = 3; d_a = 8'h5A;
        en_b = 1; wr_b = 1; addr_b = 4; d_b = 8'h6B;
        n = 0;
        while (o_busy && n < 100) begin
            clear_req = (n == 5);
            cyc();
            n++;
            if (n == 8) begin
                chk("busy_hold_a", o_q_a, 8'h11);
                chk("busy_hold_b", o_q_b, 8'h33);
                chk("busy_coll",   o_coll, 0);
            end
        end
        idle_ports();
        clear_req = 0;
        chk("clr_len", n, 16);
        en_a = 1; addr_a = 3; en_b = 1; addr_b = 4;
        cyc();
        chk("busy_wr_a_o", o_q_a, 8'hA5);
        chk("busy_wr_b_o", o_q_b, 8'hA5);
        chk("busy_wr_a_n", n_q_a, 8'h00);
        chk("busy_wr_b_n", n_q_b, 8'h00);
        idle_ports();

        // Reset in the middle of a requested sweep
        en_a = 1; wr_a = 1; addr_a = 12; d_a = 8'h3C;
        cyc();
        wr_a = 0;
        cyc();
        chk("pre_rst_q", o_q_a, 8'h3C);
        idle_ports();
        clear_req = 1;
        cyc();
        clear_req = 0;
        repeat (7) cyc();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", o_busy, 1);
        chk("mid_rst_q_a",  o_q_a,  0);
        chk("mid_rst_q_b",  o_q_b,  0);
        chk("mid_rst_coll", o_coll, 0);
        cyc();
        reset_n = 1'b1;
        wait_sweep(n);
        chk("restart_len", n, 16);
        en_a = 1; addr_a = 12; en_b = 1; addr_b = 7;
        cyc();
        chk("restart_a12", o_q_a, 8'hA5);
        chk("restart_a7",  o_q_b, 8'hA5);
        idle_ports();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/dpram_init.md
DPRAM_INIT -- requirements
Module: dpram_init

Interface
REQ-001 The block SHALL have the parameter ADDR_WIDTH, default 8; it sets the address width, and depth = 2**ADDR_WIDTH words.
REQ-002 The block SHALL have the parameter DATA_WIDTH, default 8; it sets the word width.
REQ-003 The block SHALL have the parameter BYTE_WIDTH, default 8; it sets the byte-enable lane width, and DATA_WIDTH SHALL be an integer multiple of it (NB = DATA_WIDTH/BYTE_WIDTH).
REQ-004 The block SHALL have the parameter CLEAR_VALUE, default 0; it is the word written by the clear sweep.
REQ-005 The block SHALL have the parameter RDW_NEW, default 0; 0 = read-during-write returns old data, 1 = returns new data.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-007 Port: clock  in  1  single clock, all logic on rising edge.
REQ-008 Port: reset_n  in  1  asynchronous active-low reset.
REQ-009 Port: clear_req  in  1  one-cycle request to clear the whole memory.
REQ-010 Port: busy  out  1  high while the clear sweep runs.
REQ-011 Ports: enable_a, enable_b  in  1  per-port access enable.
REQ-012 Ports: wren_a, wren_b  in  1  per-port write enable.
REQ-013 Ports: be_a, be_b  in  NB  per-port byte-lane write enables.
REQ-014 Ports: address_a, address_b  in  ADDR_WIDTH  word address.
REQ-015 Ports: data_a, data_b  in  DATA_WIDTH  write data.
REQ-016 Ports: q_a, q_b  out  DATA_WIDTH  registered read data.
REQ-017 Port: collision  out  1  one-cycle pulse on a same-address dual write.

Function
REQ-018 FSM states SHALL be IDLE and CLEAR; reset release enters CLEAR with the sweep counter at 0.
REQ-019 In CLEAR, the block SHALL write CLEAR_VALUE to address = counter each cycle, increment the counter, and go to IDLE the cycle after writing address 2**ADDR_WIDTH-1; a full sweep takes 2**ADDR_WIDTH cycles.
REQ-020 busy SHALL equal (state == CLEAR), registered.
REQ-021 In IDLE, clear_req=1 SHALL enter CLEAR on the next edge with the counter at 0; clear_req in CLEAR SHALL be ignored, with no restart.
REQ-022 While busy=1, port accesses SHALL be ignored: no writes, q_a/q_b hold, collision=0.
REQ-023 In IDLE with enable_x=1, q_x SHALL update exactly 1 cycle after the address is presented; with enable_x=0, q_x SHALL hold.
REQ-024 A write SHALL occur when enable_x & wren_x; only lanes with be_x[i]=1 are written and other lanes keep their old value.
REQ-025 Same-port read-during-write: q_x SHALL be the pre-write word if RDW_NEW=0, or the merged post-write word if RDW_NEW=1.
REQ-026 Cross-port, where one port writes and the other reads the same address in the same cycle, the reader SHALL return the old word if RDW_NEW=0 and the new merged word if RDW_NEW=1.
REQ-027 Both ports writing the same address in the same cycle: lanes enabled on port A SHALL take data_a; lanes enabled only on port B SHALL take data_b; collision SHALL pulse high for 1 cycle.
REQ-028 Address arithmetic SHALL be unsigned ADDR_WIDTH bits; the sweep counter SHALL be ADDR_WIDTH+1 bits wide so termination is detected without wrap.

Reset
REQ-029 On reset_n=0, asynchronously: q_a=0, q_b=0, collision=0, busy=1, state=CLEAR, counter=0.
REQ-030 Memory contents SHALL NOT be reset directly; they are defined only after the sweep completes.
REQ-031 Reset asserted mid-sweep SHALL restart the sweep from address 0 after release.

Structure
REQ-032 Package dpram_pkg SHALL hold the FSM state type (IDLE, CLEAR) and the RDW mode constants.
REQ-033 Sub-module dpram_clear_seq SHALL contain the FSM, the sweep counter and busy, and output the sweep address and sweep write strobe.

Verification
REQ-034 Reset release, ADDR_WIDTH=4, CLEAR_VALUE=8'hA5 -> busy high 16 cycles, then every address reads 8'hA5.
REQ-035 DATA_WIDTH=16: write A[3]=16'h1234 with be=2'b11, then A[3]=16'hFF00 with be=2'b10 -> read returns 16'hFF34 one cycle later.
REQ-036 Port A writes 8'h11 and port B writes 8'h22 to address 5, same cycle, full be -> memory[5]=8'h11 and collision=1 for exactly 1 cycle.
REQ-037 Port A writes 8'h77 to address 9 while port B reads address 9, old value 8'h00 -> q_b=8'h00 if RDW_NEW=0, 8'h77 if RDW_NEW=1.
REQ-038 clear_req pulsed at IDLE, then reset_n low at sweep address 7 -> outputs are at reset values immediately, and after release the sweep restarts at 0 and a full 2**ADDR_WIDTH busy period follows.
REQ-039 Port writes issued while busy=1 -> memory is unchanged, reads back CLEAR_VALUE, and q_a/q_b hold.
